// File: rtl/axil_nld_drive_ramp_master.sv
// AXI4-Lite master that ramps the NLD drive register (Q2.14) to a target in fixed steps.
// Define AXIL_VERIFY_EN to read back and compare the drive register after every OKAY write.
module axil_nld_drive_ramp_master #(
    parameter int C_M_AXI_ADDR_WIDTH = 4,
    parameter int C_M_AXI_DATA_WIDTH = 32,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0] DRIVE_ADDR = 4'h4,
    parameter int INTERVAL = 48
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic                              start,
    input  logic [15:0]                       target_drive,
    input  logic [15:0]                       step_size,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [15:0]                       cur_drive,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready
);
    localparam int SW = C_M_AXI_DATA_WIDTH / 8;
    localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(INTERVAL - 1);
    localparam logic [SW-1:0] STRB_LO16 = {{(SW-2){1'b0}}, 2'b11};

    typedef enum logic [3:0] {
        IDLE, RD_ADDR, RD_DATA, CALC, WR, WR_RESP, WAIT, DONE, VERIFY_RA, VERIFY_RD
    } state_t;

    state_t        state;
    logic [15:0]   tgt_r, step_r, nxt, calc_next;
    logic [16:0]   sum_up;
    logic [15:0]   diff_dn;
    logic [CW-1:0] wait_cnt;
    logic          unused_rdata;

    assign unused_rdata = ^m_axi_rdata[C_M_AXI_DATA_WIDTH-1:16];

    // Next drive value; the 17-bit sum keeps the rising path from wrapping past 0xFFFF.
    always_comb begin
        sum_up    = {1'b0, cur_drive} + {1'b0, step_r};
        diff_dn   = cur_drive - tgt_r;
        calc_next = tgt_r;
        if (step_r != 16'd0) begin
            if (cur_drive < tgt_r) begin
                if (sum_up < {1'b0, tgt_r}) calc_next = sum_up[15:0];
            end else if (cur_drive > tgt_r) begin
                if (diff_dn > step_r) calc_next = cur_drive - step_r;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            cur_drive     <= '0;
            tgt_r         <= '0;
            step_r        <= '0;
            nxt           <= '0;
            wait_cnt      <= '0;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
        end else begin
            case (state)
                // DONE is not busy, so a start landing on the done pulse is accepted.
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        tgt_r         <= target_drive;
                        step_r        <= step_size;
                        error         <= 1'b0;
                        busy          <= 1'b1;
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= DRIVE_ADDR;
                        state         <= RD_ADDR;
                    end
                end
                RD_ADDR: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= RD_DATA;
                end
                RD_DATA: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    cur_drive    <= m_axi_rdata[15:0];
                    if (m_axi_rresp != 2'b00) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (cur_drive == tgt_r) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        nxt           <= calc_next;
                        m_axi_awaddr  <= DRIVE_ADDR;
                        m_axi_awvalid <= 1'b1;
                        m_axi_wdata   <= {{(C_M_AXI_DATA_WIDTH-16){1'b0}}, calc_next};
                        m_axi_wstrb   <= STRB_LO16;
                        m_axi_wvalid  <= 1'b1;
                        state         <= WR;
                    end
                end
                WR: begin
                    if (m_axi_awready) m_axi_awvalid <= 1'b0;
                    if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
                    if ((!m_axi_awvalid || m_axi_awready) && (!m_axi_wvalid || m_axi_wready)) begin
                        m_axi_bready <= 1'b1;
                        state        <= WR_RESP;
                    end
                end
                WR_RESP: if (m_axi_bvalid) begin
                    m_axi_bready <= 1'b0;
                    if (m_axi_bresp != 2'b00) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cur_drive <= nxt;
`ifdef AXIL_VERIFY_EN
                        m_axi_arvalid <= 1'b1;
                        m_axi_araddr  <= DRIVE_ADDR;
                        state         <= VERIFY_RA;
`else
                        if (nxt == tgt_r) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            wait_cnt <= '0;
                            state    <= WAIT;
                        end
`endif
                    end
                end
`ifdef AXIL_VERIFY_EN
                VERIFY_RA: if (m_axi_arready) begin
                    m_axi_arvalid <= 1'b0;
                    m_axi_rready  <= 1'b1;
                    state         <= VERIFY_RD;
                end
                VERIFY_RD: if (m_axi_rvalid) begin
                    m_axi_rready <= 1'b0;
                    if (m_axi_rresp != 2'b00 || m_axi_rdata[15:0] != nxt) begin
                        error <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (nxt == tgt_r) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= '0;
                        state    <= WAIT;
                    end
                end
`endif
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) state <= CALC;
                    else wait_cnt <= wait_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axil_nld_drive_ramp_master.sv
// Bench for axil_nld_drive_ramp_master: behavioural AXI-Lite slave plus a write-data scoreboard.
module tb_axil_nld_drive_ramp_master;
    localparam int AW = 4;
    localparam int DW = 32;
    localparam int IV = 8;

    logic          aclk, aresetn, start;
    logic [15:0]   target_drive, step_size;
    logic          busy, done, error;
    logic [15:0]   cur_drive;
    logic [AW-1:0] m_axi_awaddr, m_axi_araddr;
    logic          m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [DW-1:0] m_axi_wdata, m_axi_rdata;
    logic [3:0]    m_axi_wstrb;
    logic [1:0]    m_axi_bresp, m_axi_rresp;
    logic          m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic          m_axi_rvalid, m_axi_rready;

    axil_nld_drive_ramp_master #(.INTERVAL(IV)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .target_drive(target_drive),
        .step_size(step_size), .busy(busy), .done(done), .error(error), .cur_drive(cur_drive),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
        .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Slave knobs and bookkeeping
    logic [15:0] drive_reg = 16'd0;
    logic [15:0] exp_q[$];
    int          w_delay = 0, wcnt = 0, cyc = 0, last_b = -1, last_r = 0, min_gap = 0;
    int          ar_cnt = 0, done_cyc = 0;
    logic [1:0]  wr_resp = 2'b00, rd_resp = 2'b00;
    bit          force_zero = 0, wrote = 0, hold_wr = 0, aw_first = 0;
    bit          aw_got = 0, w_got = 0, rd_pending = 0;
    logic [15:0] w_val = 16'd0;
    bit          ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic [31:0] wdata_cap;
    logic [3:0]  wstrb_cap, awaddr_cap, araddr_cap;

    always @(posedge aclk) cyc <= cyc + 1;

    // Record handshakes exactly as the DUT saw them at the edge.
    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ar_hs <= 0; r_hs <= 0; aw_hs <= 0; w_hs <= 0; b_hs <= 0;
        end else begin
            ar_hs      <= m_axi_arvalid && m_axi_arready;
            r_hs       <= m_axi_rvalid && m_axi_rready;
            aw_hs      <= m_axi_awvalid && m_axi_awready;
            w_hs       <= m_axi_wvalid && m_axi_wready;
            b_hs       <= m_axi_bvalid && m_axi_bready;
            wdata_cap  <= m_axi_wdata;
            wstrb_cap  <= m_axi_wstrb;
            awaddr_cap <= m_axi_awaddr;
            araddr_cap <= m_axi_araddr;
        end
    end

    always @(negedge aclk) begin
        if (!aresetn) begin
            m_axi_arready = 0; m_axi_rvalid = 0; m_axi_awready = 0; m_axi_wready = 0;
            m_axi_bvalid = 0; aw_got = 0; w_got = 0; rd_pending = 0; wcnt = 0;
        end else begin
            if (r_hs) begin m_axi_rvalid = 0; last_r = cyc; end
            if (rd_pending) begin
                m_axi_rvalid = 1;
                m_axi_rdata  = {16'hA5A5, (force_zero && wrote) ? 16'h0000 : drive_reg};
                m_axi_rresp  = rd_resp;
                rd_pending   = 0;
            end
            if (ar_hs) begin
                m_axi_arready = 0; rd_pending = 1; ar_cnt++;
                chk("araddr", araddr_cap, 4);
            end else if (m_axi_arvalid && !m_axi_arready) m_axi_arready = 1;

            if (aw_got) wcnt++;
            if (aw_hs) begin
                m_axi_awready = 0; aw_got = 1;
                chk("awaddr", awaddr_cap, 4);
                if (last_b >= 0 && (min_gap == 0 || cyc - last_b < min_gap)) min_gap = cyc - last_b;
            end else if (m_axi_awvalid && !m_axi_awready && !aw_got && !hold_wr) m_axi_awready = 1;
            if (w_hs) begin
                m_axi_wready = 0; w_got = 1; w_val = wdata_cap[15:0];
                chk("wstrb", wstrb_cap, 3);
                chk("wr_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("wdata", wdata_cap, {16'd0, exp_q.pop_front()});
            end else if (m_axi_wvalid && !m_axi_wready && !w_got && !hold_wr &&
                         (w_delay == 0 || (aw_got && wcnt >= w_delay))) m_axi_wready = 1;
            if (m_axi_wvalid && !m_axi_awvalid) aw_first = 1;

            if (b_hs) begin m_axi_bvalid = 0; last_b = cyc; end
            if (aw_got && w_got && !m_axi_bvalid) begin
                m_axi_bvalid = 1; m_axi_bresp = wr_resp;
                if (wr_resp == 2'b00) drive_reg = w_val;
                wrote = 1; aw_got = 0; w_got = 0; wcnt = 0;
            end
        end
    end

    function automatic void model(input int cur, input int tgt, input int stp);
        while (cur != tgt) begin
            int nx;
            if (stp == 0) nx = tgt;
            else if (cur < tgt) nx = (cur + stp >= tgt) ? tgt : cur + stp;
            else nx = (cur - tgt <= stp) ? tgt : cur - stp;
            exp_q.push_back(16'(nx));
            cur = nx;
        end
    endfunction

    task automatic ramp(input logic [15:0] init, input logic [15:0] tgt, input logic [15:0] stp,
                        input string tag);
        int n = 0;
        drive_reg = init; last_b = -1; min_gap = 0; wrote = 0; aw_first = 0;
        @(negedge aclk);
        start = 1; target_drive = tgt; step_size = stp;
        @(negedge aclk);
        start = 0;
        chk({tag, "_busy"}, busy, 1);
        chk({tag, "_err_clr"}, error, 0);
        while (!done && n < 20000) begin @(negedge aclk); n++; end
        chk({tag, "_done"}, done, 1);
        done_cyc = cyc;
        @(negedge aclk);
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        int n;
        aresetn = 0; start = 0; target_drive = 0; step_size = 0;
        m_axi_awready = 0; m_axi_wready = 0; m_axi_bvalid = 0; m_axi_bresp = 0;
        m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rdata = 0; m_axi_rresp = 0;
        repeat (3) @(negedge aclk);
        chk("rst_flags", {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                          m_axi_bready, m_axi_rready}, 0);
        chk("rst_cur", cur_drive, 0);
        chk("rst_addr_strb", {m_axi_awaddr, m_axi_araddr, m_axi_wstrb}, 0);
        aresetn = 1;

        exp_q = '{16'd17408, 16'd18432, 16'd19456, 16'd20480};
        ramp(16384, 20480, 1024, "up");
        chk("up_cur", cur_drive, 20480);
        chk("up_err", error, 0);
`ifdef AXIL_VERIFY_EN
        chk("up_gap", min_gap >= IV + 2, 1);
`else
        chk("up_gap", min_gap, IV + 2);
`endif

        exp_q = '{16'd19000, 16'd18000, 16'd17000, 16'd16384};
        ramp(20000, 16384, 1000, "down");
        chk("down_cur", cur_drive, 16384);

        ramp(16384, 16384, 1024, "equal");
        chk("equal_latency", (done_cyc - last_r) <= 3, 1);
        chk("equal_cur", cur_drive, 16384);

        exp_q = '{16'd65535};
        ramp(0, 65535, 0, "jump");
        chk("jump_cur", cur_drive, 65535);

        w_delay = 5; wr_resp = 2'b10;
        exp_q = '{16'd17408};
        ramp(16384, 20480, 1024, "berr");
        chk("berr_err", error, 1);
        chk("berr_cur", cur_drive, 16384);
        chk("berr_aw_first", aw_first, 1);
        w_delay = 0; wr_resp = 2'b00;
        exp_q = '{16'd17408};
        ramp(16384, 17408, 0, "recover");
        chk("recover_err", error, 0);
        chk("recover_cur", cur_drive, 17408);

        for (int i = 0; i < 3; i++) begin
            logic [15:0] a, b, s;
            a = 16'($urandom_range(0, 65535));
            b = 16'($urandom_range(0, 65535));
            s = (i == 2) ? 16'd0 : 16'($urandom_range(1000, 8000));
            model(a, b, s);
            ramp(a, b, s, "rand");
            chk("rand_cur", cur_drive, b);
        end

`ifdef AXIL_VERIFY_EN
        force_zero = 1;
        exp_q = '{16'd17408};
        ramp(16384, 17408, 0, "vfy");
        chk("vfy_err", error, 1);
        force_zero = 0;
`endif

        hold_wr = 1; drive_reg = 100;
        @(negedge aclk);
        start = 1; target_drive = 200; step_size = 0;
        @(negedge aclk);
        start = 0;
        n = 0;
        while (!m_axi_awvalid && n < 100) begin @(negedge aclk); n++; end
        chk("mid_awvalid", {m_axi_awvalid, busy}, 2'b11);
        #2 aresetn = 0;
        #1;
        chk("mid_rst_flags", {busy, done, error, m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
                              m_axi_bready, m_axi_rready}, 0);
        chk("mid_rst_cur", cur_drive, 0);
        exp_q.delete(); hold_wr = 0;
        @(negedge aclk);
        aresetn = 1;
        n = ar_cnt;
        exp_q = '{16'd200};
        ramp(100, 200, 0, "fresh");
        chk("fresh_read", ar_cnt > n, 1);
        chk("fresh_cur", cur_drive, 200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/axil_nld_drive_ramp_master.md
Name: axil_nld_drive_ramp_master

Overview:
- AXI4-Lite master (initiator) that glides the NLD drive register (offset 0x4, Q2.14) from its current value to a commanded target.
- Ramps in fixed steps, one write per INTERVAL cycles, so drive changes do not click.
- Sits between the system control logic and the NLD block's AXI-Lite slave port; it is the other end of that slave interface.

Parameters:
- C_M_AXI_ADDR_WIDTH, 4, AXI-Lite address width.
- C_M_AXI_DATA_WIDTH, 32, AXI-Lite data width; drive is carried in bits [15:0].
- DRIVE_ADDR, 4'h4, byte address of the drive register.
- INTERVAL, 48, idle cycles between a write response and the next write (>=1).

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request; ignored while busy=1.
- target_drive  in  16  ramp end value, unsigned Q2.14; sampled on accepted start.
- step_size  in  16  unsigned increment per write; sampled on accepted start; 0 = jump directly to target.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at the end of a ramp, normal or error.
- error  out  1  sticky; cleared on next accepted start.
- cur_drive  out  16  last value read or successfully written.
- m_axi_awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready: standard AXI4-Lite write channels.
- m_axi_araddr/arvalid/arready, rdata/rresp/rvalid/rready: standard AXI4-Lite read channels.

Behaviour:
- Reset (async assert, sync release): all outputs 0, awaddr=araddr=0, wstrb=0, FSM=IDLE.
- States: IDLE -> RD_ADDR -> RD_DATA -> CALC -> WR -> WR_RESP -> WAIT -> CALC ... -> DONE -> IDLE.
- IDLE: on start, latch target and step, clear error, set busy. arvalid=1 and araddr=DRIVE_ADDR on the next cycle.
- RD_ADDR: hold arvalid and araddr until arready, then drop arvalid.
- RD_DATA: rready=1. On rvalid, cur_drive=rdata[15:0].
  - rresp!=0: error=1, go to DONE.
- CALC (1 cycle):
  - cur==target: go to DONE, issuing zero further writes.
  - Rising, cur<target: next=min(cur+step,target), computed in 17 bits with no wrap.
  - Falling, cur>target: next = target if (cur-target)<=step, else cur-step.
  - step=0 behaves as step=infinity, so next=target.
- WR:
  - awvalid=wvalid=1, awaddr=DRIVE_ADDR, wdata={16'b0,next}, wstrb=4'b0011.
  - Each valid drops independently after its own ready; both handshakes may complete in the same cycle or in either order.
  - Go to WR_RESP when both channels are done.
- WR_RESP: bready=1. On bvalid:
  - bresp!=0: error=1, go to DONE; cur_drive is not updated.
  - Otherwise cur_drive=next.
  - Then, if next==target go to DONE, else go to WAIT.
- WAIT: count INTERVAL cycles, then go to CALC.
- DONE: done=1 for exactly one cycle, busy=0, return to IDLE.
- Valid stability: no valid is deasserted before its handshake; address and data are stable while valid.
- At most one outstanding transaction at any time.
- Reset mid-transaction: all valids and readies drop immediately; the slave-side outcome is the system's concern.
- A start during busy is dropped and does not queue.
- Write count for a ramp = ceil(|target-cur|/step), or 1 if step=0 and cur!=target.

Optional Feature:
- Macro: AXIL_VERIFY_EN.
- Defined: after each OKAY write response, FSM inserts VERIFY_RA/VERIFY_RD states that read DRIVE_ADDR.
  - rdata[15:0]!=next or rresp!=0: error=1, go to DONE.
  - Match: proceed to WAIT or DONE as above.
- Undefined: no readback; write response alone is trusted.

Test Plan:
- Slave reads drive=16384; start, target=20480, step=1024 -> 4 writes (17408,18432,19456,20480) with >=INTERVAL idle cycles between writes; done pulse; cur_drive=20480; error=0.
- Read 20000, target=16384, step=1000 -> writes 19000,18000,17000,16384; last write clamped to target, no undershoot.
- Read 16384, target=16384 -> one read, zero writes, done within 3 cycles of rvalid.
- Step=0, read 0, target=65535 -> single write of 65535; no 16-bit overflow on any path.
- Slave delays wready 5 cycles after awready, then returns bresp=2'b10 -> awvalid drops first, wvalid held until wready; error=1, done pulse, cur_drive unchanged; next start clears error.
- aresetn asserted while awvalid=1 and busy=1 -> all outputs 0 asynchronously; new start after release begins a fresh read. With AXIL_VERIFY_EN, readback mismatch (slave returns 0x0000) -> error=1.
